// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register cores: register offsets within the
// slave window, the slave handshake state encoding, and the overrun counter
// ceiling with its saturating increment.
package opb_reg_pkg;

    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;

    localparam logic [7:0] OVR_MAX    = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } opb_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == OVR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Generic OPB slave handshake: samples the bus every cycle, decodes the address
// window, and sequences IDLE -> ACK (one cycle) -> HOLD (until select drops).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   select_i, addr_i   OPB select and address (LSB-numbered here)
//   rnw_i, be_i        direction and byte enables (be_i[0] = least-significant byte)
//   wdata_i            OPB write data (LSB-numbered)
//   ack_o              transfer acknowledge, high for the whole ACK state
//   rd_o               one-cycle read strobe on the IDLE->ACK edge
//   wr_o               one-cycle write strobe during the ACK state
//   off_o              byte offset of the sampled address within the window
//   be_o, wdata_o      sampled byte enables and write data for the register file
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter int unsigned C_AWIDTH   = 32,
    parameter int unsigned C_DWIDTH   = 32,
    parameter int unsigned C_OFFW     = 8,
    parameter logic [31:0] C_BASEADDR = 32'h01094500,
    parameter logic [31:0] C_HIGHADDR = 32'h010945FF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    select_i,
    input  logic [C_AWIDTH-1:0]     addr_i,
    input  logic                    rnw_i,
    input  logic [C_DWIDTH/8-1:0]   be_i,
    input  logic [C_DWIDTH-1:0]     wdata_i,
    output logic                    ack_o,
    output logic                    rd_o,
    output logic                    wr_o,
    output logic [C_OFFW-1:0]       off_o,
    output logic [C_DWIDTH/8-1:0]   be_o,
    output logic [C_DWIDTH-1:0]     wdata_o
);

    opb_state_e                state_q, state_d;
    logic                      sel_q;
    logic [C_AWIDTH-1:0]       addr_q;
    logic                      rnw_q;
    logic [C_DWIDTH/8-1:0]     be_q;
    logic [C_DWIDTH-1:0]       wdata_q;
    logic                      hit;

    // Bus inputs are registered first, so the hit decision is made one edge
    // after select is sampled; the master holds address/data until the ack,
    // so the sampled copies are still valid during the ACK state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= select_i;
            addr_q  <= addr_i;
            rnw_q   <= rnw_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
        end
    end

    assign hit = sel_q && (addr_q >= C_BASEADDR) && (addr_q <= C_HIGHADDR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = HOLD;
            HOLD:    if (!sel_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ack_o   = (state_q == ACK);
    assign rd_o    = (state_q == IDLE) && hit && rnw_q;
    assign wr_o    = (state_q == ACK) && !rnw_q;
    // Low bits of (addr - base) equal the difference of the low bits.
    assign off_o   = addr_q[C_OFFW-1:0] - C_BASEADDR[C_OFFW-1:0];
    assign be_o    = be_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/opb_register_simulink2ppc_latched.sv
// OPB slave register carrying samples from fabric to the PowerPC. Fabric logic
// captures user_data_in into a shadow register on user_valid; software reads it
// over OPB, with an unread flag, a saturating overrun count and a freeze control.
// Ports:
//   OPB_Clk, OPB_Rst_n           clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW/select  OPB master request (MSB-numbered buses)
//   OPB_seqAddr                  unused
//   Sl_DBus, Sl_xferAck          read data (zero outside the ack) and acknowledge
//   Sl_errAck/retry/toutSup      tied low
//   user_data_in, user_valid     fabric sample and capture strobe
//   user_unread, user_frozen     unread flag and freeze state
// Map: 0x00 DATA (RO), 0x04 STATUS (unread bit0, overrun [15:8]),
//      0x08 CTRL (bit0 freeze R/W, bit1 clear-overrun write pulse).
module opb_register_simulink2ppc_latched
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01094500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010945FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid,
    output logic                      user_unread,
    output logic                      user_frozen
);

    logic [C_OPB_AWIDTH-1:0]   abus;
    logic [C_OPB_DWIDTH/8-1:0] be;
    logic [C_OPB_DWIDTH-1:0]   dbus;

    logic                      rd, wr;
    logic [7:0]                off;
    logic [7:0]                off_word;
    logic [C_OPB_DWIDTH/8-1:0] wr_be;
    logic [C_OPB_DWIDTH-1:0]   wr_data;

    logic [31:0]               shadow_q, shadow_d;
    logic                      unread_q, unread_d;
    logic [7:0]                ovr_q, ovr_d;
    logic                      freeze_q, freeze_d;
    logic [C_OPB_DWIDTH-1:0]   rdata_q, rdata_d;

    logic                      consume;
    logic                      ctrl_wr;
    logic                      unused_bits;

    // Whole-vector assignment maps MSB-numbered bit 0 onto bit W-1.
    assign abus = OPB_ABus;
    assign be   = OPB_BE;
    assign dbus = OPB_DBus;

    opb_slave_ack_fsm #(
        .C_AWIDTH   (C_OPB_AWIDTH),
        .C_DWIDTH   (C_OPB_DWIDTH),
        .C_OFFW     (8),
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk_i    (OPB_Clk),
        .rst_ni   (OPB_Rst_n),
        .select_i (OPB_select),
        .addr_i   (abus),
        .rnw_i    (OPB_RNW),
        .be_i     (be),
        .wdata_i  (dbus),
        .ack_o    (Sl_xferAck),
        .rd_o     (rd),
        .wr_o     (wr),
        .off_o    (off),
        .be_o     (wr_be),
        .wdata_o  (wr_data)
    );

    assign off_word = {off[7:2], 2'b00};
    assign consume  = rd && (off_word == REG_DATA);
    assign ctrl_wr  = wr && (off_word == REG_CTRL) && wr_be[0];

    always_comb begin
        shadow_d = shadow_q;
        unread_d = unread_q;
        ovr_d    = ovr_q;
        freeze_d = freeze_q;
        rdata_d  = '0;

        if (rd) begin
            case (off_word)
                REG_DATA:   rdata_d = C_OPB_DWIDTH'(shadow_q);
                REG_STATUS: rdata_d = C_OPB_DWIDTH'({16'h0, ovr_q, 7'h0, unread_q});
                REG_CTRL:   rdata_d = C_OPB_DWIDTH'(freeze_q);
                default:    rdata_d = '0;
            endcase
        end

        if (consume) begin
            unread_d = 1'b0;
        end

        // A capture on the consume edge re-arms unread and is not an overrun;
        // the read still returns the old shadow value selected above.
        if (user_valid && !freeze_q) begin
            shadow_d = user_data_in;
            unread_d = 1'b1;
            if (unread_q && !consume) begin
                ovr_d = sat_inc(ovr_q);
            end
        end

        // Placed last so a clear beats a coincident overrun increment.
        if (ctrl_wr) begin
            freeze_d = wr_data[0];
            if (wr_data[1]) begin
                ovr_d = '0;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            shadow_q <= '0;
            unread_q <= 1'b0;
            ovr_q    <= '0;
            freeze_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            unread_q <= unread_d;
            ovr_q    <= ovr_d;
            freeze_q <= freeze_d;
            rdata_q  <= rdata_d;
        end
    end

    assign Sl_DBus     = rdata_q;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_unread = unread_q;
    assign user_frozen = freeze_q;

    assign unused_bits = ^{OPB_seqAddr, off[1:0], wr_be[C_OPB_DWIDTH/8-1:1],
                           wr_data[C_OPB_DWIDTH-1:2]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
module tb_opb_register_simulink2ppc_latched;

    localparam logic [31:0] BASE = 32'h01094500;
    localparam logic [31:0] HIGH = 32'h010945FF;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_valid;
    logic        user_unread;
    logic        user_frozen;

    int checks = 0;
    int errors = 0;

    opb_register_simulink2ppc_latched #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5")
    ) dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst_n    (OPB_Rst_n),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_unread  (user_unread),
        .user_frozen  (user_frozen)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [31:0] d);
        user_valid   = 1'b1;
        user_data_in = d;
        @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        user_valid   = 1'b0;
    endtask

    // One OPB transfer. Optionally pulses user_valid before cycle pv_at
    // (cycle 1 = edge that samples select). Returns the read data, number of
    // ack cycles, the cycle of the first ack, and a count of cycles in which
    // Sl_DBus was non-zero outside a read ack.
    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be_v, input int pv_at, input logic [31:0] pv_data,
                        output logic [31:0] rdata, output int ack_n, output int ack_k,
                        output int bad);
        logic [31:0] obs;
        rdata = '0; ack_n = 0; ack_k = 0; bad = 0;
        OPB_select = 1'b1;
        OPB_RNW    = rnw;
        OPB_ABus   = addr;
        OPB_DBus   = rnw ? 32'h0 : wdata;
        OPB_BE     = be_v;
        for (int k = 1; k <= 10; k++) begin
            if (k == pv_at) begin
                user_valid   = 1'b1;
                user_data_in = pv_data;
            end
            @(posedge OPB_Clk);
            @(negedge OPB_Clk);
            user_valid = 1'b0;
            obs = Sl_DBus;
            if (Sl_xferAck) begin
                ack_n++;
                if (ack_n == 1) begin
                    ack_k = k;
                    rdata = obs;
                    if (!rnw && obs != 32'h0) bad++;
                end
                OPB_select = 1'b0;
            end else if (obs != 32'h0) begin
                bad++;
            end
            if (ack_n > 0 && k >= ack_k + 3) break;
        end
        OPB_select = 1'b0;
        OPB_RNW    = 1'b0;
        OPB_DBus   = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        int an, ak, bad;
        xfer(1'b1, BASE + off, 32'h0, 4'hF, 0, 32'h0, d, an, ak, bad);
        check({tag, "_data"}, d, exp);
        check({tag, "_acks"}, 32'(an), 32'd1);
        check({tag, "_bus"}, 32'(bad), 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] off, input logic [31:0] d,
                          input logic [3:0] be_v, input int pv_at, input logic [31:0] pv_data);
        logic [31:0] r;
        int an, ak, bad;
        xfer(1'b0, BASE + off, d, be_v, pv_at, pv_data, r, an, ak, bad);
        check({tag, "_acks"}, 32'(an), 32'd1);
        check({tag, "_bus"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int an, ak, bad;

        OPB_Rst_n    = 1'b0;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b0;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_valid   = 1'b0;
        repeat (3) @(negedge OPB_Clk);
        check("rst_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("rst_dbus", Sl_DBus, 32'h0);
        check("rst_ties", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
        check("rst_user", {30'h0, user_unread, user_frozen}, 32'h0);
        OPB_Rst_n = 1'b1;
        repeat (2) @(negedge OPB_Clk);

        // First status read: ack latency and single-cycle ack.
        xfer(1'b1, BASE + 32'h4, 32'h0, 4'hF, 0, 32'h0, d, an, ak, bad);
        check("st0_data", d, 32'h0);
        check("st0_ackcyc", 32'(ak), 32'd2);
        check("st0_acks", 32'(an), 32'd1);
        check("st0_bus", 32'(bad), 32'd0);

        // Capture and consume.
        capture(32'hDEADBEEF);
        check("unread_set", {31'h0, user_unread}, 32'h1);
        rd_chk("data1", 32'h0, 32'hDEADBEEF);
        check("unread_clr", {31'h0, user_unread}, 32'h0);
        rd_chk("st1", 32'h4, 32'h0);

        // Overrun counting and saturation, then clear.
        capture(32'h1);
        capture(32'h2);
        capture(32'h3);
        rd_chk("st_ovr2", 32'h4, 32'h0000_0201);
        for (int i = 0; i < 300; i++) capture(32'h1000_0000 + 32'(i));
        rd_chk("st_sat", 32'h4, 32'h0000_FF01);
        wr_chk("clr", 32'h8, 32'h2, 4'b0001, 0, 32'h0);
        rd_chk("st_clr", 32'h4, 32'h0000_0001);
        rd_chk("ctrl0", 32'h8, 32'h0);
        rd_chk("data_last", 32'h0, 32'h1000_012B);

        // Freeze.
        wr_chk("frz_on", 32'h8, 32'h1, 4'b0001, 0, 32'h0);
        check("frozen1", {31'h0, user_frozen}, 32'h1);
        capture(32'h12345678);
        check("frz_unread", {31'h0, user_unread}, 32'h0);
        rd_chk("frz_data", 32'h0, 32'h1000_012B);
        rd_chk("ctrl1", 32'h8, 32'h1);
        wr_chk("frz_be", 32'h8, 32'h0, 4'b1110, 0, 32'h0);
        check("frozen_be", {31'h0, user_frozen}, 32'h1);
        wr_chk("frz_off", 32'h8, 32'h0, 4'b0001, 0, 32'h0);
        check("frozen0", {31'h0, user_frozen}, 32'h0);

        // Capture on the same edge as a DATA read consumes the shadow.
        capture(32'h11111111);
        xfer(1'b1, BASE, 32'h0, 4'hF, 2, 32'hA5A5A5A5, d, an, ak, bad);
        check("coin_data", d, 32'h11111111);
        check("coin_acks", 32'(an), 32'd1);
        check("coin_unread", {31'h0, user_unread}, 32'h1);
        rd_chk("coin_st", 32'h4, 32'h0000_0001);
        rd_chk("coin_new", 32'h0, 32'hA5A5A5A5);

        // Clear-overrun write coincident with an overrun event.
        capture(32'h1);
        capture(32'h2);
        wr_chk("clr_coin", 32'h8, 32'h2, 4'b0001, 3, 32'h3);
        rd_chk("clr_coin_st", 32'h4, 32'h0000_0001);

        // Window boundaries.
        xfer(1'b1, HIGH + 32'h4, 32'h0, 4'hF, 0, 32'h0, d, an, ak, bad);
        check("oow_acks", 32'(an), 32'd0);
        check("oow_bus", 32'(bad), 32'd0);
        rd_chk("off10", 32'h10, 32'h0);
        rd_chk("offFC", 32'hFC, 32'h0);

        // Reset while the slave is in HOLD.
        capture(32'hCAFEF00D);
        wr_chk("frz_on2", 32'h8, 32'h1, 4'b0001, 0, 32'h0);
        OPB_select = 1'b1;
        OPB_RNW    = 1'b1;
        OPB_ABus   = BASE + 32'h4;
        repeat (3) @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        check("hold_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("hold_user", {30'h0, user_unread, user_frozen}, 32'h3);
        OPB_Rst_n = 1'b0;
        #1;
        check("hrst_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("hrst_dbus", Sl_DBus, 32'h0);
        check("hrst_user", {30'h0, user_unread, user_frozen}, 32'h0);
        OPB_select = 1'b0;
        OPB_RNW    = 1'b0;
        repeat (2) @(negedge OPB_Clk);
        OPB_Rst_n = 1'b1;
        @(negedge OPB_Clk);
        xfer(1'b1, BASE + 32'h4, 32'h0, 4'hF, 0, 32'h0, d, an, ak, bad);
        check("post_st", d, 32'h0);
        check("post_ackcyc", 32'(ak), 32'd2);
        rd_chk("post_data", 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_latched.md
Name: opb_register_simulink2ppc_latched

Overview:
- OPB slave register, opposite direction to the ppc2simulink software-write registers: user fabric logic writes 32-bit samples, the PowerPC reads them over OPB.
- Captures user_data_in on a user_valid strobe into a shadow register.
- Tracks an unread flag and a saturating overrun count, and offers a software freeze control.
- Sits on the same OPB bus as the other register cores in the system wrapper; single clock domain (user logic runs on OPB_Clk).

Parameters:
- C_BASEADDR, 32'h01094500, first byte address of the slave window.
- C_HIGHADDR, 32'h010945FF, last byte address of the window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex5", target family string; no functional effect.

Ports:
- OPB_Clk  in  1  sole clock; user-side ports are also synchronous to it.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  address, bit 0 = MSB.
- OPB_BE  in  [0:3]  byte enables; BE[3] = least-significant byte.
- OPB_DBus  in  [0:31]  write data, bit 0 = MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero except in the ack cycle.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_in  in  [31:0]  sample from fabric.
- user_valid  in  1  capture strobe.
- user_unread  out  1  shadow holds data software has not yet read.
- user_frozen  out  1  mirrors CTRL.freeze.

Behaviour:
- Bit mapping: Sl_DBus[i] = value[31-i]; OPB_DBus is mapped the same way.
- Register map (offset = addr - C_BASEADDR):
  - 0x00 DATA: RO, shadow[31:0].
  - 0x04 STATUS: RO; bit0 = unread, bits[15:8] = overrun count, all other bits 0.
  - 0x08 CTRL: bit0 = freeze (R/W); bit1 = clear-overrun (write-1 pulse, reads 0).
  - 0x0C..0xFF: read 0; writes ignored but acked.
- Hit: OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- FSM states:
  - IDLE: on hit go to ACK.
  - ACK: exactly one cycle; Sl_xferAck=1; Sl_DBus driven with the registered read value when RNW=1, else 0. Go to HOLD.
  - HOLD: wait until OPB_select=0, then IDLE. Back-to-back selects require the master to deassert select between transfers.
- Latency: select/address sampled at edge N; xferAck high for the cycle after edge N+1.
- Read data is registered on the IDLE->ACK edge; DATA returns the shadow value as of that edge.
- Writes: CTRL is updated at the ACK cycle only when BE[3]=1; bits on BE[0:2] are ignored.
- Capture: at an edge with user_valid=1 and freeze=0:
  - shadow <= user_data_in; unread <= 1.
  - If unread was already 1 and the shadow is not being consumed this cycle: overrun <= min(overrun+1, 255). The count saturates at 255 and never wraps.
- Consume: a DATA read clears unread at the IDLE->ACK edge.
- Simultaneous consume + capture: new data is captured; unread stays 1; overrun does not increment; the read returns the old value.
- Clear-overrun write coincident with an overrun event: clear wins, count = 0.
- freeze=1: user_valid is ignored; the shadow and unread flag hold.
- Reset (async assert, released synchronously with the clock by the system):
  - Sl_* = 0, FSM = IDLE.
  - shadow = 0, unread = 0, overrun = 0, freeze = 0.
  - user_unread = 0, user_frozen = 0.
  - Reset during ACK or HOLD aborts the transfer with no ack; the master's timeout handles recovery.

Decomposition:
- Shared package opb_reg_pkg holds:
  - offset constants REG_DATA=0x00, REG_STATUS=0x04, REG_CTRL=0x08;
  - the FSM state enum (IDLE, ACK, HOLD);
  - OVR_MAX=255.
- One sub-module, opb_slave_ack_fsm: address hit, IDLE/ACK/HOLD sequencing, and read/write strobe generation. It is reusable by the other OPB register cores.
- Capture, flags and register mux stay in the top module.

Test Plan:
- Reset then read 0x04 -> xferAck exactly one cycle after select is sampled; Sl_DBus all 0; Sl_DBus is 0 in every other cycle.
- user_valid with 0xDEADBEEF, then read 0x00 -> Sl_DBus[0:31] = 0xDEADBEEF; user_unread falls after the read; a following 0x04 read returns 0x00000000.
- Three captures with no read, then read 0x04 -> bit0 = 1, bits[15:8] = 2. 300 captures -> count = 255. Write 0x2 to 0x08 -> count = 0.
- Write 0x1 to 0x08 (BE=0001), then user_valid with 0x12345678 -> a DATA read returns the prior value; user_frozen = 1. Same write with BE=1110 -> freeze unchanged.
- DATA read whose IDLE->ACK edge coincides with user_valid 0xA5A5A5A5 -> the read returns the old value; unread stays 1; overrun unchanged.
- Reads of address C_HIGHADDR+4, and reads of offset 0x10 -> no ack for the out-of-window read; in-window offset 0x10 reads 0. Assert OPB_Rst_n low during HOLD -> all outputs 0 immediately, FSM returns to IDLE.
